bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
- Parametrised bus arbiter for the serial-bus interconnect; next generation of the fixed-priority master/slave selector.
- Masters post a target slave ID (0 = no request). The arbiter grants one master at a time and holds the grant until release or timeout.
- Arbitration mode is selectable: fixed priority or round robin. A one-cycle bus turnaround is inserted between grants.
- Outputs drive the master/slave multiplexer select lines.

Parameters:
- NO_MASTERS, 3, number of masters; minimum 2.
- NO_SLAVES, 5, number of slaves; IDs 1..NO_SLAVES are valid, 0 means idle.
- S_ID_WIDTH, $clog2(NO_SLAVES+1), slave ID width.
- M_ID_WIDTH, $clog2(NO_MASTERS), master index width.
- MAX_HOLD, 255, maximum cycles a grant may be held before forced release; must be >= 1.
- HOLD_WIDTH, $clog2(MAX_HOLD+1), hold counter width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstN  input  1  synchronous, active-low reset.
- slave_id  input  [S_ID_WIDTH-1:0] x NO_MASTERS  requested slave per master; 0 = no request.
- done  input  NO_MASTERS  per-master release; only the bit of the granted master is honoured.
- rr_mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin.
- master  output  M_ID_WIDTH  index of the granted or last-granted master.
- slave  output  S_ID_WIDTH  slave ID of the current or last grant.
- grant_valid  output  1  high while a grant is active.
- grant  output  NO_MASTERS  one-hot grant; all zero when grant_valid = 0.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (sampled on the clk edge while rstN = 0):
  - State = IDLE; master = 0, slave = 0, grant_valid = 0, grant = 0, timeout = 0, hold counter = 0.
  - RR pointer last = NO_MASTERS-1, so the first RR search starts at master 0.
  - A reset mid-grant drops the grant at that edge.
- Request validity: a request is valid only when 1 <= slave_id[i] <= NO_SLAVES. Out-of-range IDs are ignored, as if 0.
- State machine, IDLE -> BUSY -> TURN -> IDLE.
- IDLE:
  - Each cycle, evaluate valid requests combinationally.
  - rr_mode = 0: lowest index wins. rr_mode = 1: search indices last+1, last+2, ... with wrap modulo NO_MASTERS; first valid wins.
  - rr_mode is sampled only in IDLE.
  - If a winner w exists, the next edge sets: state = BUSY; master = w; slave = slave_id[w]; grant = 1<<w; grant_valid = 1; hold counter = 0; last = w (updated in both modes).
  - Latency from request to grant is 1 cycle.
- BUSY:
  - slave is frozen for the whole grant; later changes to slave_id[w] are ignored, except a change to 0.
  - The hold counter increments each cycle.
  - Release when done[w] = 1 or slave_id[w] = 0.
  - Force-release when the counter reaches MAX_HOLD-1 with no release pending; the following edge asserts timeout for 1 cycle.
  - On release, the next edge sets state = TURN, grant_valid = 0, grant = 0.
  - master and slave keep their last values.
  - If release and the timeout condition occur in the same cycle, it is a normal release and timeout stays 0.
  - done bits of non-granted masters are ignored.
- TURN: exactly one cycle, no grant regardless of requests, then IDLE.
- Gap between consecutive grants is 2 cycles (TURN + IDLE evaluation edge).
- A master still requesting after release re-competes normally. In RR mode it has the lowest priority next round.
- grant is always one-hot or zero. grant_valid == |grant.

Test Plan:
- Reset, then M1 slave_id = 3 -> one edge later master = 1, slave = 3, grant = 3'b010, grant_valid = 1. done[1] pulse -> grant_valid = 0 next edge, 1 cycle TURN, back to IDLE.
- rr_mode = 0; M0 = 2, M2 = 4 held constant, each grant released by done after 2 cycles -> M0 granted every time, M2 starved.
- rr_mode = 1, same requests -> grants alternate M0 (slave 2), M2 (slave 4), M0, ... Then add M1 = 5 -> order M0, M1, M2.
- MAX_HOLD = 4; M2 granted, never releases -> grant drops after 4 BUSY cycles, timeout pulses once (1 cycle). done[2] on the 4th cycle -> no timeout.
- M0 slave_id = 6 (with NO_SLAVES = 5) and M1 = 1 -> M1 granted. During M1's grant, done[0] = 1 and a change of M1's ID to 4 -> no effect, slave stays 1. M1's ID set to 0 -> release.
- Assert rstN = 0 for 1 cycle mid-BUSY -> all outputs 0 at that edge. A request present after reset in RR mode is granted starting from master 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Bus arbiter: grants one master to its target slave, in fixed-priority or round-robin order.
// Grant appears one edge after the request; held until done, an ID of 0, or MAX_HOLD cycles.
module bus_arbiter_rr #(
    parameter int NO_MASTERS = 3,
    parameter int NO_SLAVES  = 5,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES+1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS),
    parameter int MAX_HOLD   = 255,
    parameter int HOLD_WIDTH = $clog2(MAX_HOLD+1)
) (
    input  logic                                  clk,
    input  logic                                  rstN,
    input  logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] slave_id,
    input  logic [NO_MASTERS-1:0]                 done,
    input  logic                                  rr_mode,
    output logic [M_ID_WIDTH-1:0]                 master,
    output logic [S_ID_WIDTH-1:0]                 slave,
    output logic                                  grant_valid,
    output logic [NO_MASTERS-1:0]                 grant,
    output logic                                  timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

    state_t                  state_q, state_d;
    logic [M_ID_WIDTH-1:0]   master_q, master_d;
    logic [S_ID_WIDTH-1:0]   slave_q, slave_d;
    logic                    gv_q, gv_d;
    logic [NO_MASTERS-1:0]   grant_q, grant_d;
    logic                    timeout_q, timeout_d;
    logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
    logic [M_ID_WIDTH-1:0]   last_q, last_d;

    logic [NO_MASTERS-1:0]   req_vld;
    logic                    win_found;
    logic [M_ID_WIDTH-1:0]   win_idx;
    logic [M_ID_WIDTH-1:0]   idx_m;
    logic                    release_req;

    always_comb begin
        for (int i = 0; i < NO_MASTERS; i++) begin
            req_vld[i] = (slave_id[i] != '0) && (slave_id[i] <= S_ID_WIDTH'(NO_SLAVES));
        end
    end

    // Walk candidates from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_m     = '0;
        for (int k = NO_MASTERS; k >= 1; k--) begin
            if (rr_mode) begin
                idx_m = M_ID_WIDTH'((int'(last_q) + k) % NO_MASTERS);
            end else begin
                idx_m = M_ID_WIDTH'(k - 1);
            end
            if (req_vld[idx_m]) begin
                win_found = 1'b1;
                win_idx   = idx_m;
            end
        end
    end

    assign release_req = done[master_q] || (slave_id[master_q] == '0);

    always_comb begin
        state_d   = state_q;
        master_d  = master_q;
        slave_d   = slave_q;
        gv_d      = gv_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = BUSY;
                    master_d         = win_idx;
                    slave_d          = slave_id[win_idx];
                    gv_d             = 1'b1;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    hold_d           = '0;
                    last_d           = win_idx;
                end
            end
            BUSY: begin
                hold_d = hold_q + HOLD_WIDTH'(1);
                // A release in the limit cycle wins over the forced release.
                if (release_req || (hold_q == HOLD_WIDTH'(MAX_HOLD-1))) begin
                    state_d   = TURN;
                    gv_d      = 1'b0;
                    grant_d   = '0;
                    timeout_d = !release_req;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= IDLE;
            master_q  <= '0;
            slave_q   <= '0;
            gv_q      <= 1'b0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= M_ID_WIDTH'(NO_MASTERS-1);
        end else begin
            state_q   <= state_d;
            master_q  <= master_d;
            slave_q   <= slave_d;
            gv_q      <= gv_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign master      = master_q;
    assign slave       = slave_q;
    assign grant_valid = gv_q;
    assign grant       = grant_q;
    assign timeout     = timeout_q;

endmodule
